// File: rtl/dice_pkg.sv
// Shared types and constants for the dice_roller block and its LFSR.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [2:0] DIE_MIN  = 3'd1;
  localparam logic [2:0] DIE_MAX  = 3'd6;
  localparam logic [2:0] DIE_NONE = 3'd0;
  localparam int         LFSR_W   = 16;

  // Feedback taps at bits 15, 13, 12 and 10 (x^16 + x^14 + x^13 + x^11 + 1)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // The low three LFSR bits form one candidate die draw
  function automatic logic [2:0] lfsrDraw(input logic [LFSR_W-1:0] s);
    return s[2:0];
  endfunction

  // True when a draw lands on a real die face (1..6)
  function automatic logic isFace(input logic [2:0] d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage

// File: rtl/dice_roller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; an all-zero seed is replaced by 1
// so the register can never start in the lock-up state.
module lfsr16
  import dice_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] state_o
);

  localparam logic [LFSR_W-1:0] SEED_FIXED =
    (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Shift left by one, inserting the XOR of the tapped bits
  always_comb begin
    state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
  end

  // Always enabled: the sequence advances every clock out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED_FIXED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/dice_roller.sv
// Automated dice source feeding one die value per turn over valid/ready.
// Rejection-samples the LFSR low bits into 1..6 with a bounded retry count,
// tracks which player owns the roll and stops rolling once the game is over.
// Optional: define DICE_EXTRA_TURN_EN so a six grants the same player
// another turn (at most two bonus turns in a row).
module dice_roller
  import dice_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int                MAX_SPIN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic       game_over,
  input  logic       dice_ready,
  output logic [2:0] dice_val,
  output logic       dice_valid,
  output logic       player,
  output logic       busy,
  output logic [7:0] roll_count
);

  localparam logic [7:0] SPIN_LIMIT = 8'(MAX_SPIN);

  logic [LFSR_W-1:0] lfsrState;
  logic [2:0]        draw;

  state_e     state_q,     state_d;
  logic [2:0] diceVal_q,   diceVal_d;
  logic       diceValid_q, diceValid_d;
  logic       player_q,    player_d;
  logic       busy_q,      busy_d;
  logic [7:0] rollCount_q, rollCount_d;
  logic [7:0] spinCnt_q,   spinCnt_d;
  logic [7:0] spinNext;
`ifdef DICE_EXTRA_TURN_EN
  logic [1:0] sixRun_q,    sixRun_d;
`endif

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .state_o(lfsrState)
  );

  assign draw     = lfsrDraw(lfsrState);
  assign spinNext = spinCnt_q + 8'd1;

  // Next-state logic for the roll FSM, the turn owner and the counters
  always_comb begin
    state_d     = state_q;
    diceVal_d   = diceVal_q;
    diceValid_d = diceValid_q;
    player_d    = player_q;
    rollCount_d = rollCount_q;
    spinCnt_d   = spinCnt_q;
`ifdef DICE_EXTRA_TURN_EN
    sixRun_d    = sixRun_q;
`endif
    case (state_q)
      IDLE: begin
        if (roll_req && !game_over) begin
          state_d   = ROLL;
          spinCnt_d = '0;
        end
      end
      ROLL: begin
        if (isFace(draw)) begin
          diceVal_d   = draw;
          diceValid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          spinCnt_d = spinNext;
          if (spinNext >= SPIN_LIMIT) begin
            diceVal_d   = DIE_MIN;
            diceValid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (diceValid_q && dice_ready) begin
          diceValid_d = 1'b0;
          diceVal_d   = DIE_NONE;
          rollCount_d = rollCount_q + 8'd1;
          state_d     = IDLE;
`ifdef DICE_EXTRA_TURN_EN
          if ((diceVal_q == DIE_MAX) && (sixRun_q != 2'd2)) begin
            sixRun_d = sixRun_q + 2'd1;
          end else begin
            player_d = ~player_q;
            sixRun_d = '0;
          end
`else
          player_d = ~player_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Register the FSM state together with every output it drives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      diceVal_q   <= DIE_NONE;
      diceValid_q <= 1'b0;
      player_q    <= 1'b0;
      busy_q      <= 1'b0;
      rollCount_q <= '0;
      spinCnt_q   <= '0;
`ifdef DICE_EXTRA_TURN_EN
      sixRun_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      diceVal_q   <= diceVal_d;
      diceValid_q <= diceValid_d;
      player_q    <= player_d;
      busy_q      <= busy_d;
      rollCount_q <= rollCount_d;
      spinCnt_q   <= spinCnt_d;
`ifdef DICE_EXTRA_TURN_EN
      sixRun_q    <= sixRun_d;
`endif
    end
  end

  assign dice_val   = diceVal_q;
  assign dice_valid = diceValid_q;
  assign player     = player_q;
  assign busy       = busy_q;
  assign roll_count = rollCount_q;

endmodule
